shift_register_universal: RTL and testbench

Parametrised universal shift register for serial links and test harnesses that need a WIDTH-bit register with shift-left, shift-right, parallel-load and hold modes. It replaces fixed 4-bit serial-in/parallel-out registers. An optional frame counter detects each completed WIDTH-bit serial word and presents it on a stable latched output with a one-cycle strobe, for use by downstream deserialising logic.

---
 rtl/shift_register_universal_if.sv | 17 +
 rtl/shift_register_universal.sv | 82 ++++++++
 tb/tb_shift_register_universal.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/shift_register_universal_if.sv
// Control/data bundle for shift_register_universal: the master drives mode/en/serial/parallel inputs and the slave returns q/so/word/valid.
// Purely structural; carries no state and applies no flow control.
interface shift_register_universal_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic [1:0]       mode;
  logic             in;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             so;
  logic [WIDTH-1:0] word;
  logic             valid;

  modport master (output en, mode, in, d, input q, so, word, valid);
  modport slave  (input en, mode, in, d, output q, so, word, valid);
endinterface

// File: rtl/shift_register_universal.sv
// Universal WIDTH-bit shift register (hold/right/left/load); define SHIFT_REG_FRAME_EN for the word framer.
// q/word/valid update one edge after sampling, so is combinational; no backpressure, en=0 freezes all state.
module shift_register_universal #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic                       clk,
  input logic                       rst,
  shift_register_universal_if.slave bus
);
  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_next;

  always_comb begin
    q_next = q;
    if (bus.en) begin
      case (bus.mode)
        MODE_RIGHT: q_next = {bus.in, q[WIDTH-1:1]};
        MODE_LEFT:  q_next = {q[WIDTH-2:0], bus.in};
        MODE_LOAD:  q_next = bus.d;
        default:    q_next = q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else begin
      q <= q_next;
    end
  end

  // so always shows the bit the next shift in the selected direction will drop
  assign bus.q  = q;
  assign bus.so = (bus.mode == MODE_LEFT) ? q[WIDTH-1] : q[0];

`ifdef SHIFT_REG_FRAME_EN
  localparam int            CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] word;
  logic             valid;
  logic             shift;

  assign shift = bus.en && ((bus.mode == MODE_RIGHT) || (bus.mode == MODE_LEFT));

  // word captures the post-shift value so it matches q on the completing edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      word  <= '0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (shift) begin
        if (cnt == CNT_LAST) begin
          cnt   <= '0;
          word  <= q_next;
          valid <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else if (bus.en && (bus.mode == MODE_LOAD)) begin
        cnt <= '0;
      end
    end
  end

  assign bus.word  = word;
  assign bus.valid = valid;
`else
  assign bus.word  = '0;
  assign bus.valid = 1'b0;
`endif
endmodule

// File: tb/tb_shift_register_universal.sv
// Bench for shift_register_universal (WIDTH=4): directed vector table, reset sequences, then random traffic vs a reference model.
module tb_shift_register_universal;
  localparam int W = 4;
`ifdef SHIFT_REG_FRAME_EN
  localparam bit FRAME = 1'b1;
`else
  localparam bit FRAME = 1'b0;
`endif

  typedef struct {
    logic [1:0]   mode;
    logic         en;
    logic         in;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic         so;
    logic         valid;
    logic [W-1:0] word;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  shift_register_universal_if #(.WIDTH(W)) bus ();

  shift_register_universal #(.WIDTH(W), .RST_VAL(4'b0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive on the falling edge, return 1 time unit after the next rising edge.
  task automatic apply(input logic [1:0] mode, input logic en, input logic in, input logic [W-1:0] d);
    @(negedge clk);
    bus.mode = mode;
    bus.en   = en;
    bus.in   = in;
    bus.d    = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input logic [W-1:0] q, input logic so,
                               input logic valid, input logic [W-1:0] word);
    check({tag, ".q"}, 32'(bus.q), 32'(q));
    check({tag, ".so"}, 32'(bus.so), 32'(so));
    check({tag, ".valid"}, 32'(bus.valid), FRAME ? 32'(valid) : 32'd0);
    check({tag, ".word"}, 32'(bus.word), FRAME ? 32'(word) : 32'd0);
  endtask

  // Asserts reset between clock edges, checks it took effect at once, releases on the falling edge.
  task automatic async_reset(input string tag);
    #2;
    rst    = 1'b1;
    bus.en = 1'b0;
    #1;
    check({tag, ".rst_q"}, 32'(bus.q), 32'd0);
    check({tag, ".rst_valid"}, 32'(bus.valid), 32'd0);
    check({tag, ".rst_word"}, 32'(bus.word), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic vec_t mk(input logic [1:0] mode, input logic en, input logic in, input logic [W-1:0] d,
                              input logic [W-1:0] q, input logic so, input logic valid, input logic [W-1:0] word);
    vec_t v;
    v.mode = mode; v.en = en; v.in = in; v.d = d;
    v.q = q; v.so = so; v.valid = valid; v.word = word;
    return v;
  endfunction

  // Reference model state: value, shifts taken in the current frame, last word, strobe.
  int unsigned m_q, m_n, m_word;
  bit          m_valid;

  task automatic model_step(input logic [1:0] mode, input logic en, input logic in, input logic [W-1:0] d);
    bit shifted = 0;
    m_valid = 0;
    if (en) begin
      if (mode == 2'd1) begin
        m_q = (m_q >> 1) + (int'(in) * (1 << (W - 1)));
        shifted = 1;
      end else if (mode == 2'd2) begin
        m_q = ((m_q * 2) + int'(in)) % (1 << W);
        shifted = 1;
      end else if (mode == 2'd3) begin
        m_q = d;
        m_n = 0;
      end
    end
    if (shifted) begin
      m_n++;
      if (m_n == W) begin
        m_n     = 0;
        m_word  = m_q;
        m_valid = 1;
      end
    end
  endtask

  vec_t tbl[$];

  initial begin
    // left shift 1,0,1,1 then hold
    tbl.push_back(mk(2'd2, 1, 1, 4'h0, 4'b0001, 0, 0, 4'b0000));
    tbl.push_back(mk(2'd2, 1, 0, 4'h0, 4'b0010, 0, 0, 4'b0000));
    tbl.push_back(mk(2'd2, 1, 1, 4'h0, 4'b0101, 0, 0, 4'b0000));
    tbl.push_back(mk(2'd2, 1, 1, 4'h0, 4'b1011, 1, 1, 4'b1011));
    tbl.push_back(mk(2'd0, 1, 0, 4'h0, 4'b1011, 1, 0, 4'b1011));
    // right shift 1,0,1,1 then 4 more zeros: second strobe 4 cycles later
    tbl.push_back(mk(2'd1, 1, 1, 4'h0, 4'b1101, 1, 0, 4'b1011));
    tbl.push_back(mk(2'd1, 1, 0, 4'h0, 4'b0110, 0, 0, 4'b1011));
    tbl.push_back(mk(2'd1, 1, 1, 4'h0, 4'b1011, 1, 0, 4'b1011));
    tbl.push_back(mk(2'd1, 1, 1, 4'h0, 4'b1101, 1, 1, 4'b1101));
    tbl.push_back(mk(2'd1, 1, 0, 4'h0, 4'b0110, 0, 0, 4'b1101));
    tbl.push_back(mk(2'd1, 1, 0, 4'h0, 4'b0011, 1, 0, 4'b1101));
    tbl.push_back(mk(2'd1, 1, 0, 4'h0, 4'b0001, 1, 0, 4'b1101));
    tbl.push_back(mk(2'd1, 1, 0, 4'h0, 4'b0000, 0, 1, 4'b0000));
    // load 1010 then drain right with in=0
    tbl.push_back(mk(2'd3, 1, 0, 4'b1010, 4'b1010, 0, 0, 4'b0000));
    tbl.push_back(mk(2'd1, 1, 0, 4'h0, 4'b0101, 1, 0, 4'b0000));
    tbl.push_back(mk(2'd1, 1, 0, 4'h0, 4'b0010, 0, 0, 4'b0000));
    tbl.push_back(mk(2'd1, 1, 0, 4'h0, 4'b0001, 1, 0, 4'b0000));
    tbl.push_back(mk(2'd1, 1, 0, 4'h0, 4'b0000, 0, 1, 4'b0000));
    // load right after completion, then en=0 freeze mid-frame
    tbl.push_back(mk(2'd3, 1, 0, 4'b0110, 4'b0110, 0, 0, 4'b0000));
    tbl.push_back(mk(2'd2, 1, 1, 4'h0, 4'b1101, 1, 0, 4'b0000));
    tbl.push_back(mk(2'd2, 1, 1, 4'h0, 4'b1011, 1, 0, 4'b0000));
    tbl.push_back(mk(2'd2, 0, 0, 4'h0, 4'b1011, 1, 0, 4'b0000));
    tbl.push_back(mk(2'd3, 0, 0, 4'h0, 4'b1011, 1, 0, 4'b0000));
    tbl.push_back(mk(2'd1, 0, 0, 4'h0, 4'b1011, 1, 0, 4'b0000));
    tbl.push_back(mk(2'd2, 1, 0, 4'h0, 4'b0110, 0, 0, 4'b0000));
    tbl.push_back(mk(2'd2, 1, 0, 4'h0, 4'b1100, 1, 1, 4'b1100));
    tbl.push_back(mk(2'd0, 0, 0, 4'h0, 4'b1100, 0, 0, 4'b1100));

    bus.mode = 2'd0; bus.en = 1'b0; bus.in = 1'b0; bus.d = '0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 4'b0000, 0, 0, 4'b0000);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      apply(tbl[i].mode, tbl[i].en, tbl[i].in, tbl[i].d);
      check_outputs($sformatf("vec%0d", i), tbl[i].q, tbl[i].so, tbl[i].valid, tbl[i].word);
    end

    // two shifts into a frame, reset between edges, then a full frame of ones
    apply(2'd2, 1, 1, 4'h0);
    apply(2'd2, 1, 1, 4'h0);
    check("midframe.q", 32'(bus.q), 32'b0011);
    async_reset("midframe");
    for (int k = 1; k <= W; k++) begin
      apply(2'd2, 1, 1, 4'h0);
      check_outputs($sformatf("post_rst%0d", k), 4'((1 << k) - 1), k == W, k == W, (k == W) ? 4'b1111 : 4'b0000);
    end

    // random traffic against the model, with occasional mid-cycle resets
    async_reset("rnd_start");
    m_q = 0; m_n = 0; m_word = 0; m_valid = 0;
    for (int i = 0; i < 400; i++) begin
      logic [1:0]   mode;
      logic         en, in;
      logic [W-1:0] d;
      mode = 2'($urandom_range(0, 3));
      en   = ($urandom_range(0, 7) != 0);
      in   = 1'($urandom);
      d    = 4'($urandom);
      apply(mode, en, in, d);
      model_step(mode, en, in, d);
      check_outputs($sformatf("rnd%0d", i), 4'(m_q),
                    (mode == 2'd2) ? 1'(m_q >> (W - 1)) : 1'(m_q & 1),
                    m_valid, 4'(m_word));
      if ($urandom_range(0, 49) == 0) begin
        async_reset($sformatf("rnd%0d", i));
        m_q = 0; m_n = 0; m_word = 0; m_valid = 0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
